// File: rtl/fifo_wr_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_packer_if
//
// Bundles the narrow input stream and the wide FIFO write port of
// fifo_wr_packer.
//
// Handshake: a beat moves on a rising iclk edge where in_valid and in_ready
// are both high. in_dat and in_last are only meaningful on that edge. The
// source may not make in_valid depend on in_ready. On the FIFO side, the
// word on fifo_wr_dat is written on every edge where fifo_wr_en is high.
// fifo_wr_en is never high while fifo_full is high.
//
// Signals
//   in_valid     source -> packer   beat offered
//   in_ready     packer -> source   packer can take a beat this cycle
//   in_dat       source -> packer   beat data, IN_WIDTH bits
//   in_last      source -> packer   beat closes the current word
//   fifo_full    FIFO   -> packer   FIFO cannot take a word
//   fifo_wr_en   packer -> FIFO     write strobe
//   fifo_wr_dat  packer -> FIFO     {last flag, packed lanes}
//   wr_count     packer -> observer words written since reset, wraps
//
// Modports
//   master : the environment (stream source plus FIFO)
//   slave  : the packer
// -----------------------------------------------------------------------------
interface fifo_wr_packer_if #(
   parameter int IN_WIDTH = 8,
   parameter int RATIO    = 4
);
   logic                    in_valid;
   logic                    in_ready;
   logic [IN_WIDTH-1:0]     in_dat;
   logic                    in_last;
   logic                    fifo_full;
   logic                    fifo_wr_en;
   logic [IN_WIDTH*RATIO:0] fifo_wr_dat;
   logic [15:0]             wr_count;

   modport master (
      output in_valid,
      output in_dat,
      output in_last,
      output fifo_full,
      input  in_ready,
      input  fifo_wr_en,
      input  fifo_wr_dat,
      input  wr_count
   );

   modport slave (
      input  in_valid,
      input  in_dat,
      input  in_last,
      input  fifo_full,
      output in_ready,
      output fifo_wr_en,
      output fifo_wr_dat,
      output wr_count
   );
endinterface

// File: rtl/fifo_wr_packer.sv
// -----------------------------------------------------------------------------
// fifo_wr_packer
//
// Write-side front end of the clock-crossing FIFO. Narrow beats arriving on a
// valid/ready stream are packed little-endian, RATIO beats per FIFO word
// (beat k lands in bits [k*IN_WIDTH +: IN_WIDTH]). A beat with in_last set
// closes the word early. Lanes that received no beat hold PAD, and the word's
// MSB carries the last flag so the read side can find frame boundaries.
//
// One finished word is buffered in out_dat_q. While it waits (HOLD) the
// packer keeps taking beats as long as the FIFO is not full, so a new word
// can complete on the same edge the buffered one is written. This gives one
// write per cycle at RATIO = 1.
//
// Ports
//   iclk        in   write-domain clock
//   iclk_rst_b  in   asynchronous active-low reset
//   bus         slave modport of fifo_wr_packer_if (stream in, FIFO write out)
//   dbg_hold_o  out  FSM state: 0 = FILL (nothing buffered), 1 = HOLD
//
// Parameters
//   IN_WIDTH  width of one input beat
//   RATIO     beats per FIFO word, >= 1, power of two not required
//   PAD       value written into unfilled lanes of a flushed partial word
// -----------------------------------------------------------------------------
module fifo_wr_packer #(
   parameter int                  IN_WIDTH = 8,
   parameter int                  RATIO    = 4,
   parameter logic [IN_WIDTH-1:0] PAD      = '0
) (
   input  logic                 iclk,
   input  logic                 iclk_rst_b,
   fifo_wr_packer_if.slave      bus,
   output logic                 dbg_hold_o
);

   localparam int                LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
   localparam int                WORD_W    = IN_WIDTH * RATIO;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   state_e                             state_q,     state_d;
   logic [LANE_W-1:0]                  lane_q,      lane_d;
   logic [RATIO-1:0][IN_WIDTH-1:0]     acc_q,       acc_d;
   logic [WORD_W:0]                    out_dat_q,   out_dat_d;
   logic [15:0]                        wr_count_q,  wr_count_d;

   logic                               pending;
   logic                               accept;
   logic                               complete;
   logic                               write;
   logic [RATIO-1:0][IN_WIDTH-1:0]     base;
   logic [RATIO-1:0][IN_WIDTH-1:0]     merged;

   assign pending = (state_q == ST_HOLD);

   // The only thing that can block a beat is a buffered word the FIFO cannot
   // take this cycle. With the FIFO not full the buffered word leaves on the
   // same edge, so the register is free for whatever this beat completes.
   assign bus.in_ready   = ~pending | ~bus.fifo_full;
   assign bus.fifo_wr_en = pending & ~bus.fifo_full;
   assign bus.fifo_wr_dat = out_dat_q;
   assign bus.wr_count   = wr_count_q;
   assign dbg_hold_o     = pending;

   assign accept   = bus.in_valid & bus.in_ready;
   assign complete = accept & (bus.in_last | (lane_q == LAST_LANE));
   assign write    = bus.fifo_wr_en;

   // A beat on lane 0 starts a fresh word: every lane is seeded with PAD so a
   // flushed partial word needs no separate pad step and no stale lanes from
   // the previous word survive.
   always_comb begin
      base   = (lane_q == '0) ? {RATIO{PAD}} : acc_q;
      merged = base;
      for (int i = 0; i < RATIO; i++) begin
         if (lane_q == LANE_W'(i)) begin
            merged[i] = bus.in_dat;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      acc_d      = acc_q;
      out_dat_d  = out_dat_q;
      wr_count_d = wr_count_q;

      if (accept) begin
         acc_d = merged;
         if (complete) begin
            out_dat_d = {bus.in_last, merged};
            lane_d    = '0;
         end else begin
            lane_d    = lane_q + LANE_W'(1);
         end
      end

      if (write) begin
         wr_count_d = wr_count_q + 16'd1;
      end

      // A word completing on the draining edge reloads the buffer, so the
      // state stays in HOLD rather than passing through FILL.
      if (complete) begin
         state_d = ST_HOLD;
      end else if (write) begin
         state_d = ST_FILL;
      end
   end

   always_ff @(posedge iclk or negedge iclk_rst_b) begin
      if (!iclk_rst_b) begin
         state_q    <= ST_FILL;
         lane_q     <= '0;
         acc_q      <= '0;
         out_dat_q  <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         acc_q      <= acc_d;
         out_dat_q  <= out_dat_d;
         wr_count_q <= wr_count_d;
      end
   end

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-side front end for the clock-crossing FIFO. Accepts narrow beats on a valid/ready stream in the iclk domain and packs RATIO beats little-endian into one wide word. Drives the FIFO write port (wr_en/wr_dat) and honours the FIFO's full flag. A per-beat last marker flushes a partial word, padding the unfilled lanes and tagging the word so the read side can find frame boundaries.

Parameters:
IN_WIDTH, 8, width of one input beat.
RATIO, 4, beats per FIFO word; legal values are >= 1 (power of two not required).
PAD, 0, IN_WIDTH-bit value written into unfilled lanes of a flushed partial word.

Ports:
iclk  in  1  write-domain clock.
iclk_rst_b  in  1  reset.
in_valid  in  1  beat offered.
in_ready  out  1  beat accepted when in_valid & in_ready at posedge iclk.
in_dat  in  IN_WIDTH  beat data.
in_last  in  1  beat closes the current word (flush).
fifo_full  in  1  FIFO full flag, same clock domain.
fifo_wr_en  out  1  FIFO write strobe.
fifo_wr_dat  out  IN_WIDTH*RATIO+1  MSB = last flag; [IN_WIDTH*RATIO-1:0] = packed lanes.
wr_count  out  16  words written since reset; wraps.

Behaviour:
- Reset: iclk_rst_b is asynchronous, active-low, on clock iclk. It clears acc, lane, out_dat, pending and wr_count. fifo_wr_en = 0 and in_ready = 1 immediately, with no clock edge needed.
- State: accumulator acc (RATIO lanes), lane counter (0..RATIO-1, width max(1, clog2(RATIO))), output register out_dat with last bit, pending flag.
  - FILL: pending = 0.
  - HOLD: pending = 1.
- in_ready = ~pending | ~fifo_full. This is combinational from registered state and fifo_full.
- fifo_wr_en = pending & ~fifo_full. fifo_wr_dat = out_dat, which is registered and stable while pending.
- wr_en is never asserted while fifo_full = 1. The FIFO does not guard against overflow.
- Accepted beat, lane 0 only: the whole of acc is first set to PAD in every lane, and the beat is written into lane 0. Packing is little-endian: beat k lands in bits [k*IN_WIDTH +: IN_WIDTH].
- A beat completes a word when lane == RATIO-1 or in_last = 1. On that edge:
  - out_dat <= {in_last, acc with the current lane overwritten by in_dat; remaining lanes = PAD};
  - pending <= 1;
  - lane <= 0.
- A non-completing beat writes its lane and sets lane <= lane+1.
- Latency: the word is completed at edge T. fifo_wr_en is high in the cycle after T if fifo_full = 0, so the write happens on edge T+1.
- Drain: on an edge where fifo_wr_en = 1, pending <= 0 and wr_count <= wr_count+1, unless a new word completes on the same edge. In that case out_dat reloads and pending stays 1.
- Back-to-back operation gives full throughput: RATIO = 1 sustains one write per cycle.
- HOLD with fifo_full = 1: in_ready = 0, no beats accepted, and out_dat, acc and lane are all held.
- in_last on lane RATIO-1 gives a normal full word with the last flag set. No extra pad word is produced.
- in_last on lane 0 gives a word containing one beat and RATIO-1 PAD lanes.
- A flag-only flush (in_last with no data) is not supported. Every last marker rides on a real beat.
- Reset mid-fill or mid-hold discards the partial and pending data. No write is emitted.
- in_dat and in_last are ignored when ~(in_valid & in_ready).

Test Plan:
1. IN_WIDTH=8, RATIO=4, PAD=0, full=0; beats 11,22,33,44 on consecutive cycles -> one cycle after the 4th accept, wr_en=1 for exactly 1 cycle with wr_dat=0x0_44332211; wr_count=1.
2. Beats AA, then BB with in_last=1 -> wr_dat=0x1_0000BBAA. The next beats CC,DD,EE,FF give 0x0_FFEEDDCC, confirming lane reset and no stale data.
3. Complete a word while fifo_full=1 for 5 cycles -> wr_en=0 and in_ready=0 throughout, wr_dat stable. Dropping full gives exactly one write and in_ready returns to 1 that cycle.
4. 8 beats 01..08 continuous, full=0 -> writes 0x0_04030201 then 0x0_08070605, in_ready never deasserted, wr_count=2. With RATIO=1, 3 beats give 3 consecutive wr_en cycles.
5. Accept beats 11,22, assert iclk_rst_b=0 asynchronously mid-cycle -> outputs reset immediately, no write. After release, beats 55,66,77,88 give 0x0_88776655.
6. PAD=0xFF, beat 5A with in_last on lane 0 -> wr_dat=0x1_FFFFFF5A. Then beats 1..4 with in_last on the 4th -> 0x1_04030201, with no extra word.
